// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial adder that reuses one full-adder cell for every bit position.
//   Each cycle it produces one sum bit, LSB first, and keeps the carry in a
//   register between bits. A WIDTH-bit add therefore takes WIDTH cycles in RUN.
//
// Parameters
//   WIDTH  operand/sum width in bits (2..32)
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous reset, active-high; aborts any operation in flight
//   start  in   request; only sampled in IDLE
//   a, b   in   WIDTH-bit operands, captured when start is accepted
//   cin    in   carry-in, captured when start is accepted
//   busy   out  high while the adder is in RUN
//   done   out  one-cycle pulse; sum/cout are valid
//   sum    out  WIDTH-bit result, held until the next accepted start
//   cout   out  final carry-out, held with sum
//   ovf    out  (only when SERIAL_ADDER_OVF_EN is defined) two's-complement
//               signed overflow, held with sum
//
// Build option
//   SERIAL_ADDER_OVF_EN  adds the ovf output and its register.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_sha;
   logic [WIDTH-1:0] r_shb;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic             r_ovf;
`endif

   logic             w_bit;
   logic             w_carry_nxt;
   logic             w_last;

   // The single full-adder cell shared by all bit positions.
   assign w_bit       = r_sha[0] ^ r_shb[0] ^ r_carry;
   assign w_carry_nxt = (r_sha[0] & r_shb[0]) | (r_sha[0] & r_carry) | (r_shb[0] & r_carry);
   assign w_last      = (r_cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_sha   <= '0;
         r_shb   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         r_ovf   <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_sha   <= a;
                  r_shb   <= b;
                  r_carry <= cin;
                  r_cnt   <= '0;
                  r_sum   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
                  r_ovf   <= 1'b0;
`endif
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_carry <= w_carry_nxt;
               r_sha   <= {1'b0, r_sha[WIDTH-1:1]};
               r_shb   <= {1'b0, r_shb[WIDTH-1:1]};
               // New bit enters at the MSB so after WIDTH shifts bit 0 lands at sum[0].
               r_sum   <= {w_bit, r_sum[WIDTH-1:1]};
               r_cnt   <= r_cnt + 1'b1;
               if (w_last) begin
                  r_cout  <= w_carry_nxt;
`ifdef SERIAL_ADDER_OVF_EN
                  // On the MSB step r_carry is the carry into the MSB.
                  r_ovf   <= r_carry ^ w_carry_nxt;
`endif
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy = (r_state == S_RUN);
   assign done = (r_state == S_DONE);
   assign sum  = r_sum;
   assign cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//   Directed bench for serial_adder: a WIDTH=8 instance for the main sequence
//   and a WIDTH=2 instance for the exhaustive small-width sweep. Expected
//   results are queued when an operation is issued and compared on done.
module tb_serial_adder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // WIDTH=8 instance
   logic       start8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       cin8 = 1'b0;
   logic       busy8, done8, cout8;
   logic [7:0] sum8;
   logic       ovf8;

   // WIDTH=2 instance
   logic       start2 = 1'b0;
   logic [1:0] a2 = '0, b2 = '0;
   logic       cin2 = 1'b0;
   logic       busy2, done2, cout2;
   logic [1:0] sum2;
   logic       ovf2;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
      , .ovf(ovf8)
`endif
   );

   serial_adder #(.WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
      .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
`ifdef SERIAL_ADDER_OVF_EN
      , .ovf(ovf2)
`endif
   );

`ifndef SERIAL_ADDER_OVF_EN
   assign ovf8 = 1'b0;
   assign ovf2 = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   // {ovf, cout, sum}
   logic [9:0] q8[$];
   logic [2:0] q2[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one request on the 8-bit instance and queue its expected result.
   // Returns at the negedge after the accepting edge.
   task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c);
      logic [8:0] full;
      logic [7:0] low;
      logic       ov;
      full = {1'b0, a} + {1'b0, b} + {8'd0, c};
      low  = {1'b0, a[6:0]} + {1'b0, b[6:0]} + {7'd0, c};
      ov   = low[7] ^ full[8];
      q8.push_back({ov, full});
      @(negedge clk);
      start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
      @(negedge clk);
      start8 = 1'b0; a8 = $urandom; b8 = $urandom; cin8 = 1'($urandom);
   endtask

   // Wait for done on the 8-bit instance; pre = busy samples already skipped.
   task automatic wait_done8(input string tag, input int pre);
      int n;
      int guard;
      logic [9:0] e;
      n = pre;
      guard = 0;
      while (!done8 && guard < 40) begin
         if (busy8) n++;
         @(negedge clk);
         guard++;
      end
      check({tag, "_done_seen"}, done8, 1'b1);
      check({tag, "_busy_cycles"}, n, 8);
      check({tag, "_latency"}, guard + pre, 8);
      e = q8.pop_front();
      check({tag, "_sum"}, sum8, e[7:0]);
      check({tag, "_cout"}, cout8, e[8]);
`ifdef SERIAL_ADDER_OVF_EN
      check({tag, "_ovf"}, ovf8, e[9]);
`endif
      @(negedge clk);
      check({tag, "_done_pulse"}, done8, 1'b0);
   endtask

   task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c);
      issue8(a, b, c);
      check({tag, "_busy_at_accept"}, busy8, 1'b1);
      check({tag, "_sum_cleared"}, sum8, 8'h00);
      wait_done8(tag, 0);
   endtask

   task automatic run2(input logic [1:0] a, input logic [1:0] b, input logic c);
      int guard;
      int n;
      logic [2:0] e;
      q2.push_back({1'b0, a} + {1'b0, b} + {2'd0, c});
      @(negedge clk);
      start2 = 1'b1; a2 = a; b2 = b; cin2 = c;
      @(negedge clk);
      start2 = 1'b0;
      guard = 0;
      n = 0;
      while (!done2 && guard < 20) begin
         if (busy2) n++;
         @(negedge clk);
         guard++;
      end
      e = q2.pop_front();
      check($sformatf("w2_%0d_%0d_%0d_res", a, b, c), {cout2, sum2}, e);
      check($sformatf("w2_%0d_%0d_%0d_busy", a, b, c), n, 2);
   endtask

   initial begin
      // 1. Reset then a simple add.
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_busy", busy8, 1'b0);
      check("rst_done", done8, 1'b0);
      check("rst_sum", sum8, 8'h00);
      check("rst_cout", cout8, 1'b0);
      check("rst_ovf", ovf8, 1'b0);
      run8("t1", 8'h0F, 8'h01, 1'b0);

      // 2. Carry boundaries.
      run8("t2a", 8'hFF, 8'h01, 1'b0);
      run8("t2b", 8'hFF, 8'hFF, 1'b1);
      run8("t2c", 8'h00, 8'h00, 1'b1);

      // 3. start during RUN is ignored; result held while idle.
      issue8(8'h12, 8'h34, 1'b0);
      @(negedge clk);
      @(negedge clk);
      start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      wait_done8("t3", 3);
      for (int i = 0; i < 5; i++) begin
         check("t3_hold_sum", sum8, 8'h46);
         check("t3_hold_busy", busy8, 1'b0);
         @(negedge clk);
      end

      // Leave cout=1 so the abort reset clearing it is observable.
      run8("t4pre", 8'hFF, 8'h01, 1'b0);

      // 4. Reset during RUN aborts without done.
      @(negedge clk);
      start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      check("t4_busy_before", busy8, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t4_busy", busy8, 1'b0);
      check("t4_done", done8, 1'b0);
      check("t4_sum", sum8, 8'h00);
      check("t4_cout", cout8, 1'b0);
      for (int i = 0; i < 10; i++) begin
         check("t4_no_done", done8, 1'b0);
         @(negedge clk);
      end
      run8("t4post", 8'h01, 8'h01, 1'b0);

      // 5. Exhaustive WIDTH=2 sweep.
      for (int v = 0; v < 32; v++) begin
         logic [4:0] vv;
         vv = 5'(v);
         run2(vv[4:3], vv[2:1], vv[0]);
      end

`ifdef SERIAL_ADDER_OVF_EN
      // 6. Signed overflow.
      run8("t6a", 8'h7F, 8'h01, 1'b0);
      run8("t6b", 8'h80, 8'h80, 1'b0);
      run8("t6c", 8'h05, 8'h03, 1'b0);
`endif

      // A few random operations through the scoreboard.
      for (int i = 0; i < 6; i++) begin
         run8("rnd", 8'($urandom), 8'($urandom), 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
